// File: rtl/hilo_mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
package hilo_mdu_pkg;

    // Divider iteration count; equals the operand width.
    localparam int DIV_BITS = 32;

    // Request opcodes presented on op.
    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } mdu_op_e;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } mdu_state_e;

endpackage

// File: rtl/hilo_mdu_div_iter.sv
// Unsigned 32-bit radix-2 restoring divider datapath, one quotient bit per step.
module div_iter #(
    parameter int N_ITER = 32
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quot,
    output logic [31:0] rem,
    output logic        last
);

    logic [31:0] r_quot;
    logic [31:0] r_rem;
    logic [31:0] r_div;
    logic [5:0]  r_cnt;

    logic [32:0] w_shift;
    logic [31:0] w_sub;
    logic        w_ge;

    // Shift next dividend bit into the partial remainder and try the subtract.
    // A successful subtract always leaves a value below the divisor, so 32 bits suffice.
    assign w_shift = {r_rem, r_quot[31]};
    assign w_ge    = (w_shift >= {1'b0, r_div});
    assign w_sub   = w_shift[31:0] - r_div;

    assign quot = r_quot;
    assign rem  = r_rem;
    assign last = (r_cnt == 6'(N_ITER - 1));

    // Load operands on start, otherwise perform one restoring step per step strobe.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_quot <= '0;
            r_rem  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
        end else if (start) begin
            r_quot <= dividend;
            r_rem  <= '0;
            r_div  <= divisor;
            r_cnt  <= '0;
        end else if (step) begin
            r_rem  <= w_ge ? w_sub : w_shift[31:0];
            r_quot <= {r_quot[30:0], w_ge};
            r_cnt  <= r_cnt + 6'd1;
        end
    end

endmodule

// File: rtl/hilo_mdu.sv
// HI/LO owner: sequences MULT/MULTU/DIV/DIVU and handles MTHI/MTLO writes.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a request; MTHI/MTLO complete here
// MUL     | one cycle; HI:LO takes the 64-bit product at its end
// DIV     | 32 restoring steps on operand magnitudes
// FIX     | signs applied, HI/LO written (skipped for divide by zero)
module hilo_mdu
    import hilo_mdu_pkg::*;
#(
    parameter int DIV_BITS = hilo_mdu_pkg::DIV_BITS
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mdu_state_e  r_state;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_mul_a;
    logic [31:0] r_mul_b;
    logic        r_mul_signed;
    logic        r_q_neg;
    logic        r_r_neg;
    logic        r_wr_en;

    logic        w_is_div;
    logic        w_signed_div;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic        w_div_start;
    logic        w_div_step;
    logic        w_div_last;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_fix_q;
    logic [31:0] w_fix_r;
    logic [63:0] w_mul_a64;
    logic [63:0] w_mul_b64;
    logic [63:0] w_prod;

    assign w_is_div     = (op == OP_DIV) || (op == OP_DIVU);
    assign w_signed_div = (op == OP_DIV);
    assign w_abs_a      = (w_signed_div && op_a[31]) ? -op_a : op_a;
    assign w_abs_b      = (w_signed_div && op_b[31]) ? -op_b : op_b;
    assign w_div_start  = (r_state == ST_IDLE) && op_valid && !flush && w_is_div && (op_b != 32'd0);
    assign w_div_step   = (r_state == ST_DIV) && !flush;

    // Low 64 bits of the extended product are the same for signed and unsigned
    // once the operands are extended to 64 bits the right way.
    assign w_mul_a64 = {{32{r_mul_signed & r_mul_a[31]}}, r_mul_a};
    assign w_mul_b64 = {{32{r_mul_signed & r_mul_b[31]}}, r_mul_b};
    assign w_prod    = w_mul_a64 * w_mul_b64;

    // Truncating division: quotient negated on sign mismatch, remainder follows the dividend.
    assign w_fix_q = r_q_neg ? -w_quot : w_quot;
    assign w_fix_r = r_r_neg ? -w_rem  : w_rem;

    div_iter #(
        .N_ITER (DIV_BITS)
    ) u_div_iter (
        .clk      (clk),
        .rstn     (rstn),
        .start    (w_div_start),
        .step     (w_div_step),
        .dividend (w_abs_a),
        .divisor  (w_abs_b),
        .quot     (w_quot),
        .rem      (w_rem),
        .last     (w_div_last)
    );

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

    // Controller FSM with registered busy/done and the HI/LO registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_hi         <= '0;
            r_lo         <= '0;
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_mul_signed <= 1'b0;
            r_q_neg      <= 1'b0;
            r_r_neg      <= 1'b0;
            r_wr_en      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (flush) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (op_valid) begin
                            case (op)
                                OP_MULT, OP_MULTU: begin
                                    r_mul_a      <= op_a;
                                    r_mul_b      <= op_b;
                                    r_mul_signed <= (op == OP_MULT);
                                    r_state      <= ST_MUL;
                                    r_busy       <= 1'b1;
                                end
                                OP_DIV, OP_DIVU: begin
                                    r_q_neg <= w_signed_div & (op_a[31] ^ op_b[31]);
                                    r_r_neg <= w_signed_div & op_a[31];
                                    r_busy  <= 1'b1;
                                    if (op_b == 32'd0) begin
                                        r_wr_en <= 1'b0;
                                        r_state <= ST_FIX;
                                    end else begin
                                        r_wr_en <= 1'b1;
                                        r_state <= ST_DIV;
                                    end
                                end
                                OP_MTHI: r_hi <= op_a;
                                OP_MTLO: r_lo <= op_a;
                                default: ;
                            endcase
                        end
                    end
                    ST_MUL: begin
                        {r_hi, r_lo} <= w_prod;
                        r_done       <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                    ST_DIV: begin
                        if (w_div_last) begin
                            r_state <= ST_FIX;
                        end
                    end
                    ST_FIX: begin
                        if (r_wr_en) begin
                            r_lo <= w_fix_q;
                            r_hi <= w_fix_r;
                        end
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
